// File: rtl/jesd_pkg.sv
// Shared definitions for the JESD204B RX link controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package jesd_pkg;

  // 8b/10b control characters; each one only matches when charisk is set
  localparam logic [7:0] K_CHAR = 8'hBC;
  localparam logic [7:0] R_CHAR = 8'h1C;
  localparam logic [7:0] Q_CHAR = 8'h9C;
  localparam logic [7:0] A_CHAR = 8'h7C;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CGS       = 3'd1,
    WAIT_ILAS = 3'd2,
    ILAS      = 3'd3,
    DATA      = 3'd4
  } link_state_e;

endpackage

// File: rtl/jesd_char_detect.sv
// Per-octet /K/ /R/ /Q/ /A/ match vectors plus a beat-wide error flag.
// Latency: combinational.
// Backpressure: none; follows the decoder stream beat for beat.
module jesd_char_detect
  import jesd_pkg::*;
#(
  parameter int PARALLEL_OCTETS = 4
) (
  input  logic [8*PARALLEL_OCTETS-1:0] data_i,
  input  logic [PARALLEL_OCTETS-1:0]   charisk_i,
  input  logic [PARALLEL_OCTETS-1:0]   disperr_i,
  input  logic [PARALLEL_OCTETS-1:0]   notintable_i,
  output logic [PARALLEL_OCTETS-1:0]   is_k,
  output logic [PARALLEL_OCTETS-1:0]   is_r,
  output logic [PARALLEL_OCTETS-1:0]   is_q,
  output logic [PARALLEL_OCTETS-1:0]   is_a,
  output logic                         err
);

  // Classify each octet; a data octet with a matching value never counts
  always_comb begin
    is_k = '0;
    is_r = '0;
    is_q = '0;
    is_a = '0;
    for (int i = 0; i < PARALLEL_OCTETS; i++) begin
      is_k[i] = charisk_i[i] && (data_i[8*i +: 8] == K_CHAR);
      is_r[i] = charisk_i[i] && (data_i[8*i +: 8] == R_CHAR);
      is_q[i] = charisk_i[i] && (data_i[8*i +: 8] == Q_CHAR);
      is_a[i] = charisk_i[i] && (data_i[8*i +: 8] == A_CHAR);
    end
    err = |(disperr_i | notintable_i);
  end

endmodule

// File: rtl/jesd_rx_link_ctrl.sv
// Per-lane JESD204B RX link state: CGS, ILAS checking, user data, SYNC~ drive.
// Latency: data_o/data_valid_o one cycle after data_i; state outputs registered.
// Backpressure: none; every beat is consumed, errors are counted or force resync.
module jesd_rx_link_ctrl
  import jesd_pkg::*;
#(
  parameter int PARALLEL_OCTETS = 4,  // must equal F: one frame per beat
  parameter int F               = 4,
  parameter int K               = 8,
  parameter int CGS_BEATS       = 4,
  parameter int ILAS_MF         = 4,
  parameter int ERR_THRESH      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         link_en_i,
  input  logic [8*PARALLEL_OCTETS-1:0] data_i,
  input  logic [PARALLEL_OCTETS-1:0]   charisk_i,
  input  logic [PARALLEL_OCTETS-1:0]   disperr_i,
  input  logic [PARALLEL_OCTETS-1:0]   notintable_i,
  output logic                         sync_no,
  output logic                         mark_rst_no,
  output logic [8*PARALLEL_OCTETS-1:0] data_o,
  output logic                         data_valid_o,
  output logic [2:0]                   state_o,
  output logic [15:0]                  err_cnt_o,
  output logic                         ilas_err_o
);

  localparam int PO  = PARALLEL_OCTETS;
  localparam int BPM = F * K / PARALLEL_OCTETS;  // beats per multiframe
  localparam int BW  = (BPM > 1) ? $clog2(BPM) : 1;
  localparam int MW  = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int CW  = (CGS_BEATS > 1) ? $clog2(CGS_BEATS) : 1;
  localparam int EW  = $clog2(ERR_THRESH + 1);

  localparam logic [BW-1:0] B_LAST   = BW'(BPM - 1);
  localparam logic [MW-1:0] MF_LAST  = MW'(ILAS_MF - 1);
  localparam logic [CW-1:0] CGS_LAST = CW'(CGS_BEATS - 1);
  localparam logic [EW-1:0] E_LAST   = EW'(ERR_THRESH - 1);

  link_state_e   state;
  logic [BW-1:0] bcnt;
  logic [MW-1:0] mfcnt;
  logic [CW-1:0] cgs_cnt;
  logic [EW-1:0] econs;

  logic [PO-1:0] is_k, is_r, is_q, is_a;
  logic          err;
  logic          all_k, kr_only, ilas_bad, ilas_last;

  jesd_char_detect #(.PARALLEL_OCTETS(PO)) u_char_detect (
    .data_i       (data_i),
    .charisk_i    (charisk_i),
    .disperr_i    (disperr_i),
    .notintable_i (notintable_i),
    .is_k         (is_k),
    .is_r         (is_r),
    .is_q         (is_q),
    .is_a         (is_a),
    .err          (err)
  );

  assign all_k     = &is_k;
  assign kr_only   = &(is_k | is_r);
  assign ilas_last = (bcnt == B_LAST) && (mfcnt == MF_LAST);

  // ILAS beat check: /R/ opens every multiframe, /Q/ follows it in
  // multiframe 1, /A/ closes every multiframe, and no octet may be errored
  always_comb begin
    ilas_bad = err;
    if (bcnt == '0 && !is_r[0]) ilas_bad = 1'b1;
    if (bcnt == '0 && mfcnt == MW'(1) && !is_q[1]) ilas_bad = 1'b1;
    if (bcnt == B_LAST && !is_a[PO-1]) ilas_bad = 1'b1;
  end

  // Marker is held in reset until the /R/ beat is registered onto data_o
  assign mark_rst_no = rst_ni && (state == ILAS || state == DATA);
  assign state_o     = state;

  // Data pipeline: fixed one-cycle delay regardless of link state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) data_o <= '0;
    else         data_o <= data_i;
  end

  // Link FSM with its counters and registered SYNC~/valid/error outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      sync_no      <= 1'b0;
      data_valid_o <= 1'b0;
      ilas_err_o   <= 1'b0;
      err_cnt_o    <= '0;
      bcnt         <= '0;
      mfcnt        <= '0;
      cgs_cnt      <= '0;
      econs        <= '0;
    end else begin
      ilas_err_o   <= 1'b0;
      data_valid_o <= 1'b0;
      if (!link_en_i) begin
        state   <= IDLE;
        sync_no <= 1'b0;
        bcnt    <= '0;
        mfcnt   <= '0;
        cgs_cnt <= '0;
        econs   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CGS;
            sync_no <= 1'b0;
            cgs_cnt <= '0;
          end
          CGS: begin
            if (!err && all_k) begin
              if (cgs_cnt == CGS_LAST) begin
                state   <= WAIT_ILAS;
                sync_no <= 1'b1;
                cgs_cnt <= '0;
              end else begin
                cgs_cnt <= cgs_cnt + 1'b1;
              end
            end else begin
              cgs_cnt <= '0;
            end
          end
          WAIT_ILAS: begin
            // /R/ in octet 0 is beat 0 of multiframe 0; the rest of that
            // beat may already carry configuration octets
            if (err) begin
              state   <= CGS;
              sync_no <= 1'b0;
            end else if (is_r[0]) begin
              state <= ILAS;
              bcnt  <= BW'(1);
              mfcnt <= '0;
            end else if (!kr_only) begin
              state   <= CGS;
              sync_no <= 1'b0;
            end
          end
          ILAS: begin
            if (ilas_bad) begin
              ilas_err_o <= 1'b1;
              state      <= CGS;
              sync_no    <= 1'b0;
              bcnt       <= '0;
              mfcnt      <= '0;
            end else if (ilas_last) begin
              state <= DATA;
              bcnt  <= '0;
              mfcnt <= '0;
            end else if (bcnt == B_LAST) begin
              bcnt  <= '0;
              mfcnt <= mfcnt + 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          DATA: begin
            if (err) begin
              if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
              if (econs == E_LAST) begin
                state   <= CGS;
                sync_no <= 1'b0;
                econs   <= '0;
              end else begin
                econs        <= econs + 1'b1;
                data_valid_o <= 1'b1;
              end
            end else begin
              econs        <= '0;
              data_valid_o <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            sync_no <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
